multi_timer_counter: RTL and testbench
======================================

// Module: multi_timer_counter
// PURPOSE
//  NUM_CH independent down-counting timers, generalising the single 8-bit countdown timer.
//  Adds per-channel width parameter, start/stop (pause) control, one-shot or auto-reload
//  mode, sticky time-up flags with acknowledge, single-cycle expiry pulses and an OR'd summary.
//  Sits beside the 1 Hz timebase; feeds display/alarm logic.
// PARAMETERS
//  NUM_CH      4   number of independent timer channels (1..16)
//  CNT_W       8   counter width per channel (preset max 2^CNT_W-1 seconds)
//  WARN_THRESH 5   warning threshold; used only when TIMER_WARN_EN is defined
// PORTS
//  clk_1hz      in   1            1 Hz clock; all state changes on its rising edge
//  reset        in   1            synchronous, active-high reset
//  load         in   NUM_CH       per-channel: copy preset lane into count, go IDLE
//  preset       in   NUM_CH*CNT_W lane i = bits [i*CNT_W +: CNT_W]
//  start        in   NUM_CH       per-channel: begin/resume counting
//  stop         in   NUM_CH       per-channel: pause, count held
//  auto_reload  in   NUM_CH       per-channel mode: 0 one-shot, 1 periodic; sampled at expiry
//  ack          in   NUM_CH       per-channel: clear sticky time_up
//  count        out  NUM_CH*CNT_W current count per lane
//  running      out  NUM_CH       1 while channel is in RUN
//  time_up      out  NUM_CH       sticky expiry flag
//  expire_pulse out  NUM_CH       1-cycle pulse on every expiry
//  any_time_up  out  1            OR of time_up (registered, same edge as time_up)
//  warn         out  NUM_CH       present only with TIMER_WARN_EN
// BEHAVIOUR
//  Per-channel FSM: IDLE(0) -> RUN(1) <-> PAUSE(2); RUN -> DONE(3) (one-shot only).
//  Reset: count=preset lane, state=IDLE, running=0, time_up=0, expire_pulse=0, any_time_up=0, warn=0.
//  Priority per edge: reset > load > stop > start > decrement. Channels never interact.
//  load: count<=preset, state IDLE, time_up<=0, expire_pulse<=0; legal in any state.
//  stop: RUN->PAUSE, count held; ignored in IDLE/DONE. stop+start on same edge -> stop wins.
//  start: IDLE/PAUSE -> RUN. In DONE, start ignored (load required first).
//   Start with count==0: same edge -> expiry handling below (no decrement, no wrap).
//  RUN, count>1: count<=count-1.
//  RUN, count==1 (or start with 0): expiry edge: expire_pulse<=1, time_up<=1;
//   auto_reload=0: count<=0, state DONE, running<=0.
//   auto_reload=1: count<=preset, stay RUN; period = preset edges. preset==0 in auto-reload:
//   count stays 0, expiry every edge (pulse held high) - legal, documented.
//  Count never wraps below 0; DONE holds count=0 indefinitely.
//  expire_pulse is 1 exactly one cycle per expiry except back-to-back case above.
//  ack clears time_up; ack on an expiry edge -> set wins (time_up stays 1).
//  Outputs all registered; count visible the edge after the controlling input is sampled.
// CONFIGURATION
//  Macro TIMER_WARN_EN: if defined, warn[i]=1 while state RUN/PAUSE and 0<count<=WARN_THRESH,
//   registered, cleared on reset/load/DONE. If undefined, warn port and logic do not exist.
// STRUCTURE
//  Shared include timer_pkg.vh: state encodings ST_IDLE/ST_RUN/ST_PAUSE/ST_DONE, ST_W=2.
//  Sub-module timer_channel (one CNT_W counter + FSM), instantiated NUM_CH times via generate;
//   top only slices lanes and ORs any_time_up.
// TESTING
//  1 One-shot: preset=3, load, start -> count 3,2,1,0; expire_pulse 1 cycle at 1->0; time_up=1; state DONE.
//  2 Auto-reload: preset=2, auto_reload=1, start -> count 2,1,2,1,...; pulse every 2 edges; time_up sticky.
//  3 Pause: preset=10, run 3 edges, stop 4 edges -> count holds 7; start -> resumes 6.
//  4 Simultaneous: ack on expiry edge -> time_up stays 1; stop+start same edge -> PAUSE; load+stop -> IDLE.
//  5 Reset mid-run (count=5) -> next edge count=preset, all flags 0; ch1 unaffected by ch0 ops pre-reset.
//  6 Edge: preset=0 one-shot start -> immediate expiry, DONE, count 0; TIMER_WARN_EN: warn 1 for count 5..1.

Source files
------------

// File: rtl/timer_pkg.sv
// Shared channel FSM state encodings for the multi-channel countdown timer.
package timer_pkg;

  localparam int ST_W = 2;

  localparam logic [ST_W-1:0] ST_IDLE  = 2'd0;
  localparam logic [ST_W-1:0] ST_RUN   = 2'd1;
  localparam logic [ST_W-1:0] ST_PAUSE = 2'd2;
  localparam logic [ST_W-1:0] ST_DONE  = 2'd3;

endpackage

// File: rtl/timer_channel.sv
// One countdown channel: CNT_W counter plus IDLE/RUN/PAUSE/DONE control.
// Optional warn output exists only when TIMER_WARN_EN is defined.
module timer_channel
  import timer_pkg::*;
#(
  parameter int CNT_W = 8
`ifdef TIMER_WARN_EN
  ,
  parameter int WARN_THRESH = 5
`endif
) (
  input  logic             clk_1hz,
  input  logic             reset,
  input  logic             load,
  input  logic [CNT_W-1:0] preset,
  input  logic             start,
  input  logic             stop,
  input  logic             auto_reload,
  input  logic             ack,
  output logic [CNT_W-1:0] count,
  output logic             running,
  output logic             time_up,
  output logic             time_up_next,
  output logic             expire_pulse
`ifdef TIMER_WARN_EN
  ,
  output logic             warn
`endif
);

  logic [ST_W-1:0]  state_reg, state_next;
  logic [CNT_W-1:0] count_reg, count_next;
  logic             running_reg;
  logic             time_up_reg;
  logic             pulse_reg, pulse_next;
  logic             expiry;

  always_comb begin
    state_next   = state_reg;
    count_next   = count_reg;
    pulse_next   = 1'b0;
    time_up_next = time_up_reg & ~ack;
    expiry       = 1'b0;
    if (load) begin
      count_next   = preset;
      state_next   = ST_IDLE;
      time_up_next = 1'b0;
    end else if (stop) begin
      if (state_reg == ST_RUN) state_next = ST_PAUSE;
    end else if (state_reg == ST_RUN ||
                 (start && (state_reg == ST_IDLE || state_reg == ST_PAUSE))) begin
      // A start edge only enters RUN; it expires immediately only from zero.
      if (count_reg == '0 || (state_reg == ST_RUN && count_reg == CNT_W'(1))) begin
        expiry = 1'b1;
      end else if (state_reg == ST_RUN) begin
        count_next = count_reg - CNT_W'(1);
      end else begin
        state_next = ST_RUN;
      end
    end
    if (expiry) begin
      pulse_next   = 1'b1;
      time_up_next = 1'b1;
      if (auto_reload) begin
        count_next = preset;
        state_next = ST_RUN;
      end else begin
        count_next = '0;
        state_next = ST_DONE;
      end
    end
  end

  always_ff @(posedge clk_1hz) begin
    if (reset) begin
      state_reg   <= ST_IDLE;
      count_reg   <= preset;
      running_reg <= 1'b0;
      time_up_reg <= 1'b0;
      pulse_reg   <= 1'b0;
    end else begin
      state_reg   <= state_next;
      count_reg   <= count_next;
      running_reg <= (state_next == ST_RUN);
      time_up_reg <= time_up_next;
      pulse_reg   <= pulse_next;
    end
  end

`ifdef TIMER_WARN_EN
  logic warn_reg;

  always_ff @(posedge clk_1hz) begin
    if (reset) begin
      warn_reg <= 1'b0;
    end else begin
      warn_reg <= (state_next == ST_RUN || state_next == ST_PAUSE) &&
                  (count_next != '0) && (int'(count_next) <= WARN_THRESH);
    end
  end

  assign warn = warn_reg;
`endif

  assign count        = count_reg;
  assign running      = running_reg;
  assign time_up      = time_up_reg;
  assign expire_pulse = pulse_reg;

endmodule

// File: rtl/multi_timer_counter.sv
// NUM_CH independent countdown timers clocked by the 1 Hz timebase.
// Optional per-channel warn output enabled by defining TIMER_WARN_EN.
module multi_timer_counter
  import timer_pkg::*;
#(
  parameter int NUM_CH = 4,
  parameter int CNT_W  = 8
`ifdef TIMER_WARN_EN
  ,
  parameter int WARN_THRESH = 5
`endif
) (
  input  logic                    clk_1hz,
  input  logic                    reset,
  input  logic [NUM_CH-1:0]       load,
  input  logic [NUM_CH*CNT_W-1:0] preset,
  input  logic [NUM_CH-1:0]       start,
  input  logic [NUM_CH-1:0]       stop,
  input  logic [NUM_CH-1:0]       auto_reload,
  input  logic [NUM_CH-1:0]       ack,
  output logic [NUM_CH*CNT_W-1:0] count,
  output logic [NUM_CH-1:0]       running,
  output logic [NUM_CH-1:0]       time_up,
  output logic [NUM_CH-1:0]       expire_pulse,
`ifdef TIMER_WARN_EN
  output logic [NUM_CH-1:0]       warn,
`endif
  output logic                    any_time_up
);

  logic [NUM_CH-1:0] time_up_next;
  logic              any_time_up_reg;

  generate
    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
      timer_channel #(
        .CNT_W       (CNT_W)
`ifdef TIMER_WARN_EN
        ,
        .WARN_THRESH (WARN_THRESH)
`endif
      ) u_ch (
        .clk_1hz      (clk_1hz),
        .reset        (reset),
        .load         (load[gi]),
        .preset       (preset[gi*CNT_W +: CNT_W]),
        .start        (start[gi]),
        .stop         (stop[gi]),
        .auto_reload  (auto_reload[gi]),
        .ack          (ack[gi]),
        .count        (count[gi*CNT_W +: CNT_W]),
        .running      (running[gi]),
        .time_up      (time_up[gi]),
        .time_up_next (time_up_next[gi]),
        .expire_pulse (expire_pulse[gi])
`ifdef TIMER_WARN_EN
        ,
        .warn         (warn[gi])
`endif
      );
    end
  endgenerate

  // Built from the channels' next-state flags so it updates on the same edge as time_up.
  always_ff @(posedge clk_1hz) begin
    if (reset) any_time_up_reg <= 1'b0;
    else       any_time_up_reg <= |time_up_next;
  end

  assign any_time_up = any_time_up_reg;

endmodule

// File: tb/tb_multi_timer_counter.sv
// Directed bench for multi_timer_counter: one-shot, auto-reload, pause, priority and reset cases.
module tb_multi_timer_counter;

  localparam int NUM_CH = 4;
  localparam int CNT_W  = 8;

  logic                    clk_1hz = 1'b0;
  logic                    reset;
  logic [NUM_CH-1:0]       load, start, stop, auto_reload, ack;
  logic [NUM_CH*CNT_W-1:0] preset;
  logic [NUM_CH*CNT_W-1:0] count;
  logic [NUM_CH-1:0]       running, time_up, expire_pulse;
  logic                    any_time_up;
`ifdef TIMER_WARN_EN
  logic [NUM_CH-1:0]       warn;
`endif

  int checks = 0;
  int errors = 0;

  multi_timer_counter #(.NUM_CH(NUM_CH), .CNT_W(CNT_W)) dut (
    .clk_1hz      (clk_1hz),
    .reset        (reset),
    .load         (load),
    .preset       (preset),
    .start        (start),
    .stop         (stop),
    .auto_reload  (auto_reload),
    .ack          (ack),
    .count        (count),
    .running      (running),
    .time_up      (time_up),
    .expire_pulse (expire_pulse),
`ifdef TIMER_WARN_EN
    .warn         (warn),
`endif
    .any_time_up  (any_time_up)
  );

  always #5 clk_1hz = ~clk_1hz;

  task automatic step();
    @(posedge clk_1hz);
    #1;
  endtask

  task automatic check(input string tag, input int observed, input int expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, observed, expected);
    end
    $display("check %-22s observed %0d expected %0d", tag, observed, expected);
  endtask

  function automatic int lane(input int ch);
    return int'(count[ch*CNT_W +: CNT_W]);
  endfunction

  initial begin
    reset = 1'b1; load = '0; start = '0; stop = '0; auto_reload = '0; ack = '0;
    preset = '0;
    preset[0*CNT_W +: CNT_W] = 8'd3;
    preset[1*CNT_W +: CNT_W] = 8'd9;

    // Reset state
    step();
    check("rst_cnt0", lane(0), 3);
    check("rst_cnt1", lane(1), 9);
    check("rst_running", int'(running), 0);
    check("rst_time_up", int'(time_up), 0);
    check("rst_pulse", int'(expire_pulse), 0);
    check("rst_any", int'(any_time_up), 0);
    reset = 1'b0;

    // One-shot 3,2,1,0
    start = 4'b0001;
    step();
    start = '0;
    check("os_start_cnt", lane(0), 3);
    check("os_start_run", int'(running[0]), 1);
    step(); check("os_cnt2", lane(0), 2);
    step(); check("os_cnt1", lane(0), 1);
    check("os_pulse_pre", int'(expire_pulse[0]), 0);
    step();
    check("os_cnt0", lane(0), 0);
    check("os_pulse", int'(expire_pulse[0]), 1);
    check("os_time_up", int'(time_up[0]), 1);
    check("os_any", int'(any_time_up), 1);
    check("os_run_off", int'(running[0]), 0);
    step();
    check("os_pulse_clr", int'(expire_pulse[0]), 0);
    check("os_sticky", int'(time_up[0]), 1);
    start = 4'b0001;
    step();
    start = '0;
    check("done_ignore_cnt", lane(0), 0);
    check("done_ignore_run", int'(running[0]), 0);
    check("ch1_isolated_cnt", lane(1), 9);
    check("ch1_isolated_run", int'(running[1]), 0);

    // Ack clears sticky flag
    ack = 4'b0001;
    step();
    ack = '0;
    check("ack_time_up", int'(time_up[0]), 0);
    check("ack_any", int'(any_time_up), 0);

    // Auto-reload with preset 2: 2,1,2,1...
    preset[0*CNT_W +: CNT_W] = 8'd2;
    auto_reload = 4'b0001;
    load = 4'b0001;
    step();
    load = '0;
    check("ar_load_cnt", lane(0), 2);
    start = 4'b0001;
    step();
    start = '0;
    check("ar_start_cnt", lane(0), 2);
    step(); check("ar_cnt1", lane(0), 1);
    step();
    check("ar_reload_cnt", lane(0), 2);
    check("ar_pulse", int'(expire_pulse[0]), 1);
    check("ar_time_up", int'(time_up[0]), 1);
    check("ar_running", int'(running[0]), 1);
    step();
    check("ar_cnt1b", lane(0), 1);
    check("ar_pulse_clr", int'(expire_pulse[0]), 0);
    // Ack on expiry edge: set wins
    ack = 4'b0001;
    step();
    ack = '0;
    check("ack_exp_pulse", int'(expire_pulse[0]), 1);
    check("ack_exp_time_up", int'(time_up[0]), 1);

    // Stop and start together: stop wins
    step();
    check("ss_pre_cnt", lane(0), 1);
    stop = 4'b0001; start = 4'b0001;
    step();
    stop = '0; start = '0;
    check("ss_running", int'(running[0]), 0);
    check("ss_cnt_held", lane(0), 1);

    // Load with stop: load wins, back to IDLE
    preset[0*CNT_W +: CNT_W] = 8'd10;
    auto_reload = '0;
    load = 4'b0001; stop = 4'b0001;
    step();
    load = '0; stop = '0;
    check("ls_cnt", lane(0), 10);
    check("ls_time_up", int'(time_up[0]), 0);
    check("ls_running", int'(running[0]), 0);

    // Pause: run 3 edges to 7, hold for 4 edges, resume to 6
    start = 4'b0001;
    step();
    start = '0;
    step(); step(); step();
    check("pz_cnt7", lane(0), 7);
    stop = 4'b0001;
    step(); step(); step(); step();
    stop = '0;
    check("pz_held", lane(0), 7);
    check("pz_running", int'(running[0]), 0);
    start = 4'b0001;
    step();
    start = '0;
    check("pz_resume_cnt", lane(0), 7);
    check("pz_resume_run", int'(running[0]), 1);
    step(); check("pz_cnt6", lane(0), 6);
    step(); check("pz_cnt5", lane(0), 5);
    check("ch1_still_idle", lane(1), 9);

    // Reset mid-run
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("mr_cnt", lane(0), 10);
    check("mr_running", int'(running), 0);
    check("mr_time_up", int'(time_up), 0);
    check("mr_any", int'(any_time_up), 0);

    // Preset 0 one-shot on ch2; preset 0 auto-reload on ch3
    auto_reload = 4'b1000;
    start = 4'b1100;
    step();
    start = '0;
    check("z_os_cnt", lane(2), 0);
    check("z_os_pulse", int'(expire_pulse[2]), 1);
    check("z_os_time_up", int'(time_up[2]), 1);
    check("z_os_running", int'(running[2]), 0);
    check("z_ar_pulse", int'(expire_pulse[3]), 1);
    check("z_ar_running", int'(running[3]), 1);
    step();
    check("z_os_pulse_clr", int'(expire_pulse[2]), 0);
    check("z_ar_pulse_held", int'(expire_pulse[3]), 1);
    check("z_ar_cnt", lane(3), 0);
    check("ch1_after_all", lane(1), 9);

`ifdef TIMER_WARN_EN
    // Warn window: preset 6 on ch1, warn for counts 5..1
    preset[1*CNT_W +: CNT_W] = 8'd6;
    load = 4'b0010;
    step();
    load = '0;
    start = 4'b0010;
    step();
    start = '0;
    check("warn_cnt6", int'(warn[1]), 0);
    for (int k = 5; k >= 1; k--) begin
      step();
      check("warn_window", int'(warn[1]), 1);
    end
    step();
    check("warn_done", int'(warn[1]), 0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
